fp_denorm: RTL

FP_DENORM -- requirements
Module: fp_denorm

---
 rtl/fp_denorm.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fp_denorm.sv
// ----------------------------------------------------------------------------
// fp_denorm
//   Converts a single-precision operand (biased exponent + 23-bit mantissa,
//   sign handled elsewhere) into a 27-bit unsigned fixed-point fraction.
//   This is the inverse of the leading-one normaliser: exponent 126 places
//   the hidden one at bit 26 (weight 2^-1). The datapath is a two-stage
//   valid/ready pipeline.
//
//   Stage 1 classifies the operand (normal / overflow / underflow). It also
//   registers the right-shift amount and the 27-bit significand
//   S = {1, man, 000}.
//   Stage 2 applies the shift, optionally rounds, and registers the result
//   and the flags.
//
// Build option:
//   FP_DENORM_RND_EN  defined   -> round to nearest, ties to even
//                                  (guard + sticky)
//                     undefined -> truncate (default)
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   in_valid   in   1   operand valid
//   in_ready   out  1   operand accepted this cycle when in_valid is also 1
//   in_exp     in   8   biased exponent
//   in_man     in   23  mantissa without hidden bit
//   out_valid  out  1   result valid
//   out_ready  in   1   downstream consumes result this cycle
//   out_frac   out  27  fraction, bit 26 = 2^-1 ... bit 0 = 2^-27
//   out_ovf    out  1   operand >= 1.0, out_frac saturated to all ones
//   out_udf    out  1   operand < 2^-27, out_frac zero
// ----------------------------------------------------------------------------
module fp_denorm (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_exp,
    input  logic [22:0] in_man,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [26:0] out_frac,
    output logic        out_ovf,
    output logic        out_udf
);

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_OVF  = 2'd1,
        CLS_UDF  = 2'd2
    } cls_t;

    // Stage 1 registers
    logic        s1_valid_reg;
    logic [4:0]  s1_sh_reg;
    cls_t        s1_cls_reg;
    logic [26:0] s1_sig_reg;

    // Stage 2 registers
    logic        s2_valid_reg;
    logic [26:0] s2_frac_reg;
    logic        s2_ovf_reg;
    logic        s2_udf_reg;

    // ------------------------------------------------------------------
    // Handshake: a stage loads when it is empty or its content moves on
    // in the same cycle. Only registered state and out_ready feed
    // in_ready. rst simply forces it low while reset is held.
    // ------------------------------------------------------------------
    logic s2_load;
    logic s1_load;
    logic accept;

    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = !rst && s1_load;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 1 decode
    // ------------------------------------------------------------------
    cls_t        cls_next;
    logic [4:0]  sh_next;
    logic [7:0]  sh_wide;
    logic [26:0] sig_next;

    assign sh_wide  = 8'd126 - in_exp;
    assign sig_next = {1'b1, in_man, 3'b000};

    always_comb begin
        cls_next = CLS_NORM;
        sh_next  = 5'd0;
        if (in_exp >= 8'd127) begin
            cls_next = CLS_OVF;
        end else if (in_exp <= 8'd99) begin
            cls_next = CLS_UDF;
        end else begin
            // 100..126 gives a shift of 0..26, which fits in 5 bits
            sh_next = sh_wide[4:0];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 shift (and optional rounding)
    // ------------------------------------------------------------------
    logic [26:0] norm_frac;

`ifdef FP_DENORM_RND_EN
    // Shift S into a double-width word. The upper half is the kept
    // result. The lower half holds exactly the bits shifted out.
    logic [53:0] wide_shifted;
    logic [26:0] kept;
    logic        guard;
    logic        sticky;
    logic        round_up;

    assign wide_shifted = {s1_sig_reg, 27'd0} >> s1_sh_reg;
    assign kept         = wide_shifted[53:27];
    assign guard        = wide_shifted[26];
    assign sticky       = |wide_shifted[25:0];
    assign round_up     = guard && (sticky || kept[0]);
    // Nonzero dropped bits need sh >= 4. In that case kept < 2^23, so the
    // increment can never carry out of bit 26.
    assign norm_frac    = kept + {26'd0, round_up};
`else
    assign norm_frac    = s1_sig_reg >> s1_sh_reg;
`endif

    logic [26:0] frac_next;
    logic        ovf_next;
    logic        udf_next;

    always_comb begin
        frac_next = norm_frac;
        ovf_next  = 1'b0;
        udf_next  = 1'b0;
        case (s1_cls_reg)
            CLS_OVF: begin
                frac_next = 27'h7FFFFFF;
                ovf_next  = 1'b1;
            end
            CLS_UDF: begin
                frac_next = 27'd0;
                udf_next  = 1'b1;
            end
            default: begin
                frac_next = norm_frac;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sh_reg    <= 5'd0;
            s1_cls_reg   <= CLS_NORM;
            s1_sig_reg   <= 27'd0;
            s2_valid_reg <= 1'b0;
            s2_frac_reg  <= 27'd0;
            s2_ovf_reg   <= 1'b0;
            s2_udf_reg   <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= accept;
                if (accept) begin
                    s1_sh_reg  <= sh_next;
                    s1_cls_reg <= cls_next;
                    s1_sig_reg <= sig_next;
                end
            end
            // While out_ready is low and stage 2 is full, nothing here
            // updates, so the visible result is held.
            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_frac_reg <= frac_next;
                    s2_ovf_reg  <= ovf_next;
                    s2_udf_reg  <= udf_next;
                end
            end
        end
    end

    // Outputs read as idle for the whole cycle in which rst is high. This
    // includes the cycle before the registers clear.
    assign out_valid = s2_valid_reg && !rst;
    assign out_frac  = rst ? 27'd0 : s2_frac_reg;
    assign out_ovf   = s2_ovf_reg && !rst;
    assign out_udf   = s2_udf_reg && !rst;

endmodule
